press_classifier: RTL and testbench
===================================

PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 Parameter N, default 19: width of the free-running prescaler; one tick every 2^N clk cycles (~10 ms at 50 MHz).
REQ-002 Parameter LONG_TICKS, default 100: number of ticks a press must be held to count as long (~1 s).
REQ-003 Parameter DBL_TICKS, default 30: maximum number of ticks of release gap that still allows a double press (~300 ms).
REQ-004 clk  input  1  sole clock; all logic is on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 db  input  1  debounced button level, synchronous to clk, from the upstream debouncer.
REQ-007 short_p  output  1  one-cycle pulse on a classified single short press.
REQ-008 long_p  output  1  one-cycle pulse when a press reaches LONG_TICKS.
REQ-009 double_p  output  1  one-cycle pulse on the second press of a double press.
REQ-010 evt_cnt  output  8  running count of emitted events.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The prescaler q (N bits) shall increment every cycle and wrap; tick shall be high in the cycle when q == 2^N-1.
REQ-013 db_d shall register db each cycle; rise = db & ~db_d and fall = ~db & db_d.
REQ-014 The FSM shall have the states IDLE, PRESS1, HELD, GAP and PRESS2.
REQ-015 IDLE: on rise, clear hcnt and go to PRESS1.
REQ-016 PRESS1: on fall, clear hcnt and go to GAP.
REQ-017 PRESS1: otherwise, on tick, if hcnt == LONG_TICKS-1 pulse long_p and go to HELD; if not, increment hcnt.
REQ-018 HELD: on fall, go to IDLE with no pulse.
REQ-019 GAP: on rise, pulse double_p and go to PRESS2.
REQ-020 GAP: otherwise, on tick, if hcnt == DBL_TICKS-1 pulse short_p and go to IDLE; if not, increment hcnt.
REQ-021 PRESS2: on fall, go to IDLE; no long-press timing applies in this state.
REQ-022 When rise or fall coincides with tick, the edge shall take priority over the tick transition.
REQ-023 Pulses shall be registered: each pulse is high in the cycle after the deciding edge, is exactly one cycle wide, and at most one pulse fires per cycle.
REQ-024 evt_cnt shall increment by 1 on every short_p, long_p or double_p, wrapping from 255 to 0.
REQ-025 hcnt width shall be $clog2 of the larger of LONG_TICKS and DBL_TICKS; all compares shall be unsigned.
REQ-026 busy shall be driven combinationally from the state register.

Reset
REQ-027 On reset: state = IDLE, q = 0, hcnt = 0, evt_cnt = 0, and short_p, long_p and double_p = 0.
REQ-028 On reset, db_d shall be set to 1, so a press already held across reset is ignored until it is released and pressed again.
REQ-029 Reset asserted mid-press (in PRESS1, HELD, GAP or PRESS2) shall discard the press with no pulse, both during reset and after it deasserts.

Structure
REQ-030 The state encoding (IDLE..PRESS2) and the default values of N, LONG_TICKS and DBL_TICKS shall live in a shared package, btn_pkg.
REQ-031 The prescaler shall be a separate sub-module, tick_gen, with parameter N and an output tick; the FSM, counters and pulses stay in press_classifier.

Verification (N=2, so tick every 4 cycles; LONG_TICKS=5; DBL_TICKS=3)
REQ-032 Short press: db high 8 cycles, then low -> exactly one short_p, within 16 cycles of the fall; evt_cnt=1; no long_p or double_p.
REQ-033 Long press: db high 40 cycles -> exactly one long_p, on the 5th tick after the rise; on release, no further pulse; evt_cnt=1.
REQ-034 Double press: db high 6, low 4, high 6, then low -> one double_p, one cycle after the second rise; no short_p; evt_cnt=1; busy returns to 0 after the final fall.
REQ-035 Reset mid-press: reset for 1 cycle during PRESS1 while db stays high -> all outputs 0 and busy 0, with no pulse until db goes low then high again.
REQ-036 Counter wrap: 256 short presses -> evt_cnt reads 0; the 257th press -> evt_cnt reads 1.
REQ-037 Edge/tick collision: drive a rise in GAP in the same cycle as the expiring tick -> double_p fires and short_p does not.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the button press classifier.
// Holds the classifier state encoding and the default timing parameters
// (prescaler width, long-press length, double-press gap).
package btn_pkg;

  localparam int N_DEF          = 19;   // 2^19 cycles ~ 10 ms at 50 MHz
  localparam int LONG_TICKS_DEF = 100;  // ~1 s hold for a long press
  localparam int DBL_TICKS_DEF  = 30;   // ~300 ms release gap for a double

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HELD   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_t;

endpackage

// File: rtl/press_classifier_if.sv
// Signal bundle between the press classifier and its environment.
//   db        : debounced button level into the classifier
//   short_p   : one-cycle pulse, single short press
//   long_p    : one-cycle pulse, press held for LONG_TICKS
//   double_p  : one-cycle pulse, second press of a double press
//   evt_cnt   : 8-bit wrapping count of emitted pulses
//   busy      : classifier is not in IDLE
//   state     : current classifier state, for observation only
// Handshake: there is no valid/ready pair here. db is a level sampled every
// cycle; each pulse output is a single-cycle strobe with no backpressure, so
// the consumer must take it in the cycle it is high.
interface press_classifier_if;
  import btn_pkg::*;

  logic       db;
  logic       short_p;
  logic       long_p;
  logic       double_p;
  logic [7:0] evt_cnt;
  logic       busy;
  state_t     state;

  modport master (
    output db,
    input  short_p, long_p, double_p, evt_cnt, busy, state
  );

  modport slave (
    input  db,
    output short_p, long_p, double_p, evt_cnt, busy, state
  );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler producing a timing tick.
//   clk   : clock
//   reset : synchronous active-high reset, clears the prescaler
//   tick  : high for one cycle every 2^N cycles (when the count is all ones)
module tick_gen
  import btn_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [N-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= q + N'(1);
  end

  assign tick = (q == {N{1'b1}});

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button activity into short, long and double presses.
//   clk   : clock, all logic on the rising edge
//   reset : synchronous active-high reset
//   bus   : press_classifier_if.slave (db in; pulses, evt_cnt, busy, state out)
// Timing is measured in prescaler ticks from tick_gen. hcnt counts hold ticks
// in PRESS1 and release-gap ticks in GAP.
module press_classifier
  import btn_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int DBL_TICKS  = DBL_TICKS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  press_classifier_if.slave   bus
);

  localparam int HMAX = (LONG_TICKS > DBL_TICKS) ? LONG_TICKS : DBL_TICKS;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] DBL_LAST  = HW'(DBL_TICKS - 1);

  logic          tick;
  logic          db_d;
  logic          rise;
  logic          fall;
  state_t        state;
  logic [HW-1:0] hcnt;
  logic          short_r;
  logic          long_r;
  logic          double_r;
  logic [7:0]    evt_cnt;

  tick_gen #(.N(N)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign rise = bus.db & ~db_d;
  assign fall = ~bus.db & db_d;

  // Edges are tested before tick in every state, so an edge landing on the
  // expiring tick wins. db_d resets high so a press held through reset is not
  // seen as a rise until it is released and pressed again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hcnt     <= '0;
      db_d     <= 1'b1;
      short_r  <= 1'b0;
      long_r   <= 1'b0;
      double_r <= 1'b0;
      evt_cnt  <= 8'd0;
    end else begin
      db_d     <= bus.db;
      short_r  <= 1'b0;
      long_r   <= 1'b0;
      double_r <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            hcnt  <= '0;
            state <= PRESS1;
          end
        end
        PRESS1: begin
          if (fall) begin
            hcnt  <= '0;
            state <= GAP;
          end else if (tick) begin
            if (hcnt == LONG_LAST) begin
              long_r  <= 1'b1;
              evt_cnt <= evt_cnt + 8'd1;
              state   <= HELD;
            end else begin
              hcnt <= hcnt + HW'(1);
            end
          end
        end
        HELD: begin
          if (fall) state <= IDLE;
        end
        GAP: begin
          if (rise) begin
            double_r <= 1'b1;
            evt_cnt  <= evt_cnt + 8'd1;
            state    <= PRESS2;
          end else if (tick) begin
            if (hcnt == DBL_LAST) begin
              short_r <= 1'b1;
              evt_cnt <= evt_cnt + 8'd1;
              state   <= IDLE;
            end else begin
              hcnt <= hcnt + HW'(1);
            end
          end
        end
        PRESS2: begin
          if (fall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.short_p  = short_r;
  assign bus.long_p   = long_r;
  assign bus.double_p = double_r;
  assign bus.evt_cnt  = evt_cnt;
  assign bus.busy     = (state != IDLE);
  assign bus.state    = state;

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with N=2 (tick every 4 cycles),
// LONG_TICKS=5, DBL_TICKS=3.
module tb_press_classifier;
  import btn_pkg::*;

  localparam logic [2:0] EV_SHORT = 3'b100;
  localparam logic [2:0] EV_LONG  = 3'b010;
  localparam logic [2:0] EV_DBL   = 3'b001;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  press_classifier_if bus ();

  press_classifier #(.N(2), .LONG_TICKS(5), .DBL_TICKS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // scoreboard state
  logic [2:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int ncyc     = 0;
  int cnt_short = 0, cnt_long = 0, cnt_dbl = 0;
  int short_at = 0, long_at = 0, dbl_at = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_assert++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // pulse monitor: pops the expected event for every pulse seen
  always @(negedge clk) begin
    logic [2:0] ev;
    ncyc++;
    if (!reset && (bus.short_p || bus.long_p || bus.double_p)) begin
      ev = {bus.short_p, bus.long_p, bus.double_p};
      if (bus.short_p)  begin cnt_short++; short_at = ncyc; end
      if (bus.long_p)   begin cnt_long++;  long_at  = ncyc; end
      if (bus.double_p) begin cnt_dbl++;   dbl_at   = ncyc; end
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_pulse: observed %b expected none", ev);
      end
      if (exp_q.size() != 0) check("pulse_kind", 32'(ev), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.db = 1'b0;
    reset  = 1'b1;
    step(2);
    reset  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int start, s0, l0, d0;

    // reset state
    bus.db = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_short",  32'(bus.short_p), 0);
    check("rst_long",   32'(bus.long_p), 0);
    check("rst_double", 32'(bus.double_p), 0);
    check("rst_evt",    32'(bus.evt_cnt), 0);
    check("rst_busy",   32'(bus.busy), 0);
    check("rst_state",  32'(bus.state), 32'(IDLE));
    step(1);

    // short press: high 8, then low
    s0 = cnt_short; l0 = cnt_long; d0 = cnt_dbl;
    exp_q.push_back(EV_SHORT);
    bus.db = 1'b1;
    step(8);
    bus.db = 1'b0;
    start = ncyc;
    for (int i = 0; i < 20 && cnt_short == s0; i++) step(1);
    check("short_count", 32'(cnt_short - s0), 1);
    check_range("short_latency", short_at - start, 11, 14);
    step(10);
    check("short_evt", 32'(bus.evt_cnt), 1);
    check("short_no_long", 32'(cnt_long - l0), 0);
    check("short_no_dbl", 32'(cnt_dbl - d0), 0);
    check_idle("short");

    // long press: high 40, then release
    do_reset();
    step(1);
    l0 = cnt_long; s0 = cnt_short; d0 = cnt_dbl;
    exp_q.push_back(EV_LONG);
    bus.db = 1'b1;
    start = ncyc;
    step(3);
    check("press1_state", 32'(bus.state), 32'(PRESS1));
    step(37);
    check("long_count", 32'(cnt_long - l0), 1);
    check_range("long_latency", long_at - start, 19, 22);
    check("held_state", 32'(bus.state), 32'(HELD));
    bus.db = 1'b0;
    step(30);
    check("long_count_after", 32'(cnt_long - l0), 1);
    check("long_evt", 32'(bus.evt_cnt), 1);
    check("long_no_other", 32'((cnt_short - s0) + (cnt_dbl - d0)), 0);
    check_idle("long");

    // double press: high 6, low 4, high 6, low
    do_reset();
    step(1);
    s0 = cnt_short; d0 = cnt_dbl;
    exp_q.push_back(EV_DBL);
    bus.db = 1'b1;
    step(6);
    bus.db = 1'b0;
    step(4);
    bus.db = 1'b1;
    start = ncyc;
    step(6);
    check("dbl_count", 32'(cnt_dbl - d0), 1);
    check("dbl_latency", 32'(dbl_at - start), 2);
    check("press2_state", 32'(bus.state), 32'(PRESS2));
    bus.db = 1'b0;
    step(2);
    check("dbl_busy_after_fall", 32'(bus.busy), 0);
    step(30);
    check("dbl_no_short", 32'(cnt_short - s0), 0);
    check("dbl_evt", 32'(bus.evt_cnt), 1);
    check_idle("dbl");

    // reset mid-press with db held high
    do_reset();
    step(1);
    s0 = cnt_short; l0 = cnt_long; d0 = cnt_dbl;
    bus.db = 1'b1;
    step(3);
    check("mid_busy_before", 32'(bus.busy), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_outputs", 32'({bus.short_p, bus.long_p, bus.double_p}), 0);
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_evt", 32'(bus.evt_cnt), 0);
    step(40);
    check("mid_no_pulse", 32'((cnt_short - s0) + (cnt_long - l0) + (cnt_dbl - d0)), 0);
    check("mid_busy_held", 32'(bus.busy), 0);
    bus.db = 1'b0;
    step(5);
    check("mid_busy_released", 32'(bus.busy), 0);
    exp_q.push_back(EV_SHORT);
    bus.db = 1'b1;
    step(4);
    bus.db = 1'b0;
    step(20);
    check("mid_repress_evt", 32'(bus.evt_cnt), 1);
    check_idle("mid");

    // counter wrap: 256 short presses then one more
    do_reset();
    step(1);
    for (int p = 0; p < 256; p++) begin
      exp_q.push_back(EV_SHORT);
      bus.db = 1'b1;
      step(2);
      bus.db = 1'b0;
      step(16);
    end
    check("wrap_256", 32'(bus.evt_cnt), 0);
    exp_q.push_back(EV_SHORT);
    bus.db = 1'b1;
    step(2);
    bus.db = 1'b0;
    step(16);
    check("wrap_257", 32'(bus.evt_cnt), 1);
    check_idle("wrap");

    // edge/tick collision: fall lands on a tick, later rise lands on the
    // expiring gap tick (ticks fall on edges 4, 8, 12, 16 after reset release)
    do_reset();
    s0 = cnt_short; d0 = cnt_dbl;
    step(1);
    bus.db = 1'b1;
    step(2);
    bus.db = 1'b0;
    step(12);
    exp_q.push_back(EV_DBL);
    bus.db = 1'b1;
    start = ncyc;
    step(6);
    check("coll_dbl", 32'(cnt_dbl - d0), 1);
    check("coll_dbl_latency", 32'(dbl_at - start), 2);
    check("coll_no_short", 32'(cnt_short - s0), 0);
    bus.db = 1'b0;
    step(30);
    check("coll_no_short_after", 32'(cnt_short - s0), 0);
    check("coll_evt", 32'(bus.evt_cnt), 1);
    check_idle("coll");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
